// File: rtl/overcurrent_sense_if.sv
// Current-sense ADC sample stream feeding the overcurrent detector.
// One-cycle strobe qualifies the channel select and the sample value.
interface overcurrent_sense_if #(
    parameter int DATA_W = 12
);
    logic              sample_valid;
    logic              sample_ch;
    logic [DATA_W-1:0] sample_data;

    modport master (output sample_valid, output sample_ch, output sample_data);
    modport slave  (input  sample_valid, input  sample_ch, input  sample_data);
endinterface

// File: rtl/overcurrent_sense.sv
// Two-channel overcurrent detector: qualified trip, minimum fault hold,
// hysteresis-qualified clear, PWM gating and saturating trip counters.
//
// state    | meaning
// NORMAL   | no fault, waiting for an over sample
// PENDING  | counting consecutive over samples toward a trip
// FAULT    | fault asserted, minimum hold running, samples ignored
// CLEARING | fault asserted, counting consecutive safe samples
module overcurrent_sense #(
    parameter int DATA_W      = 12,
    parameter int TRIP_HI     = 3000,
    parameter int TRIP_LO     = 2500,
    parameter int TRIP_COUNT  = 4,
    parameter int CLEAR_COUNT = 8,
    parameter int HOLD_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    overcurrent_sense_if.slave smp,
    input  logic               ENA,
    input  logic               ENB,
    input  logic               pwm_a_in,
    input  logic               pwm_b_in,
    output logic               OCA,
    output logic               OCB,
    output logic               PWMA,
    output logic               PWMB,
    output logic [7:0]         trips_a,
    output logic [7:0]         trips_b
);
    typedef enum logic [1:0] {NORMAL, PENDING, FAULT, CLEARING} state_t;

    logic            over;
    logic            safe;
    logic [1:0]      en;
    logic [1:0]      pwm_raw;
    logic [1:0]      oc;
    logic [1:0]      pwm;
    logic [1:0][7:0] trips;

    assign over    = smp.sample_data >= DATA_W'(TRIP_HI);
    assign safe    = smp.sample_data <= DATA_W'(TRIP_LO);
    assign en      = {ENB, ENA};
    assign pwm_raw = {pwm_b_in, pwm_a_in};

    for (genvar g = 0; g < 2; g++) begin : g_ch
        state_t      state, state_n;
        logic [7:0]  trip_cnt, trip_n;
        logic [7:0]  clr_cnt, clr_n;
        logic [7:0]  trips_q, trips_n;
        logic [25:0] hold_cnt, hold_n;
        logic        oc_q;
        logic        pwm_q;
        logic        sel;
        logic        enter_fault;

        assign sel = smp.sample_valid && (smp.sample_ch == 1'(g));

        always_comb begin
            state_n     = state;
            trip_n      = trip_cnt;
            clr_n       = clr_cnt;
            hold_n      = hold_cnt;
            enter_fault = 1'b0;
            case (state)
                NORMAL: begin
                    if (sel && over) begin
                        trip_n = 8'd1;
                        if (TRIP_COUNT == 1) begin
                            state_n     = FAULT;
                            enter_fault = 1'b1;
                        end else begin
                            state_n = PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (sel) begin
                        if (over) begin
                            trip_n = trip_cnt + 8'd1;
                            if (trip_n == 8'(TRIP_COUNT)) begin
                                state_n     = FAULT;
                                enter_fault = 1'b1;
                            end
                        end else begin
                            trip_n  = '0;
                            state_n = NORMAL;
                        end
                    end
                end
                FAULT: begin
                    hold_n = hold_cnt + 26'd1;
                    // On the expiry edge an over sample is dropped, a safe one already counts
                    if (hold_n == 26'(HOLD_CYCLES)) begin
                        state_n = CLEARING;
                        clr_n   = '0;
                        if (sel && safe) begin
                            clr_n = 8'd1;
                            if (CLEAR_COUNT == 1) begin
                                state_n = NORMAL;
                                clr_n   = '0;
                                trip_n  = '0;
                            end
                        end
                    end
                end
                CLEARING: begin
                    if (sel) begin
                        if (over) begin
                            state_n     = FAULT;
                            enter_fault = 1'b1;
                        end else if (safe) begin
                            clr_n = clr_cnt + 8'd1;
                            if (clr_n == 8'(CLEAR_COUNT)) begin
                                state_n = NORMAL;
                                clr_n   = '0;
                                trip_n  = '0;
                            end
                        end else begin
                            clr_n = '0;
                        end
                    end
                end
                default: state_n = NORMAL;
            endcase
            if (enter_fault) hold_n = '0;
            trips_n = (enter_fault && trips_q != 8'hFF) ? trips_q + 8'd1 : trips_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state    <= NORMAL;
                trip_cnt <= '0;
                clr_cnt  <= '0;
                hold_cnt <= '0;
                trips_q  <= '0;
                oc_q     <= 1'b0;
                pwm_q    <= 1'b0;
            end else begin
                state    <= state_n;
                trip_cnt <= trip_n;
                clr_cnt  <= clr_n;
                hold_cnt <= hold_n;
                trips_q  <= trips_n;
                oc_q     <= (state_n == FAULT) || (state_n == CLEARING);
                pwm_q    <= pwm_raw[g] & en[g] & ~oc_q;
            end
        end

        assign oc[g]    = oc_q;
        assign pwm[g]   = pwm_q;
        assign trips[g] = trips_q;
    end

    assign OCA     = oc[0];
    assign OCB     = oc[1];
    assign PWMA    = pwm[0];
    assign PWMB    = pwm[1];
    assign trips_a = trips[0];
    assign trips_b = trips[1];
endmodule

// File: tb/tb_overcurrent_sense.sv
// Bench for overcurrent_sense: vector table, hand-written hold/clear/re-trip
// sequences, then random traffic against a timestamp-based reference model.
module tb_overcurrent_sense;
    localparam int DATA_W      = 12;
    localparam int TRIP_HI     = 3000;
    localparam int TRIP_LO     = 2500;
    localparam int TRIP_COUNT  = 4;
    localparam int CLEAR_COUNT = 8;
    localparam int HOLD        = 16;

    logic       clk;
    logic       rst_n;
    logic       ena, enb, pa, pb;
    logic       oca, ocb, pwma, pwmb;
    logic [7:0] trips_a, trips_b;

    overcurrent_sense_if #(.DATA_W(DATA_W)) smp_if ();

    overcurrent_sense #(
        .DATA_W(DATA_W), .TRIP_HI(TRIP_HI), .TRIP_LO(TRIP_LO),
        .TRIP_COUNT(TRIP_COUNT), .CLEAR_COUNT(CLEAR_COUNT), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .smp(smp_if),
        .ENA(ena), .ENB(enb), .pwm_a_in(pa), .pwm_b_in(pb),
        .OCA(oca), .OCB(ocb), .PWMA(pwma), .PWMB(pwmb),
        .trips_a(trips_a), .trips_b(trips_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: fault described by the edge it began on and run lengths
    bit m_fault[2];
    int m_fault_edge[2];
    int m_over_run[2];
    int m_safe_run[2];
    int m_trips[2];
    bit m_pwm[2];

    typedef struct {
        logic        v;
        logic        ch;
        logic [11:0] d;
        logic        en;
        logic        p;
        logic        oca;
        logic        ocb;
        logic        pwma;
        logic [7:0]  tra;
    } vec_t;
    vec_t tbl[11];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_fault[c] = 0; m_fault_edge[c] = 0; m_over_run[c] = 0;
            m_safe_run[c] = 0; m_trips[c] = 0; m_pwm[c] = 0;
        end
    endtask

    task automatic model_enter_fault(input int c);
        m_fault[c]      = 1;
        m_fault_edge[c] = cyc;
        m_safe_run[c]   = 0;
        m_over_run[c]   = 0;
        if (m_trips[c] < 255) m_trips[c]++;
    endtask

    task automatic model_edge(input bit v, input bit ch, input int d);
        bit is_over, is_safe;
        is_over = d >= TRIP_HI;
        is_safe = d <= TRIP_LO;
        m_pwm[0] = pa & ena & !m_fault[0];
        m_pwm[1] = pb & enb & !m_fault[1];
        for (int c = 0; c < 2; c++) begin
            if (v && int'(ch) == c) begin
                if (!m_fault[c]) begin
                    if (is_over) begin
                        m_over_run[c]++;
                        if (m_over_run[c] >= TRIP_COUNT) model_enter_fault(c);
                    end else begin
                        m_over_run[c] = 0;
                    end
                end else if (cyc >= m_fault_edge[c] + HOLD) begin
                    if (is_over) begin
                        if (cyc > m_fault_edge[c] + HOLD) model_enter_fault(c);
                    end else if (is_safe) begin
                        m_safe_run[c]++;
                        if (m_safe_run[c] >= CLEAR_COUNT) begin
                            m_fault[c]    = 0;
                            m_over_run[c] = 0;
                        end
                    end else begin
                        m_safe_run[c] = 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit v, input bit ch, input int d);
        smp_if.sample_valid = v;
        smp_if.sample_ch    = ch;
        smp_if.sample_data  = DATA_W'(d);
        @(posedge clk);
        cyc++;
        model_edge(v, ch, d);
        #1;
        check("oca_model",  int'(oca),     int'(m_fault[0]));
        check("ocb_model",  int'(ocb),     int'(m_fault[1]));
        check("pwma_model", int'(pwma),    int'(m_pwm[0]));
        check("pwmb_model", int'(pwmb),    int'(m_pwm[1]));
        check("trips_a_model", int'(trips_a), m_trips[0]);
        check("trips_b_model", int'(trips_b), m_trips[1]);
        smp_if.sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_oca", int'(oca), 0);
        check("rst_ocb", int'(ocb), 0);
        check("rst_pwma", int'(pwma), 0);
        check("rst_pwmb", int'(pwmb), 0);
        check("rst_trips_a", int'(trips_a), 0);
        check("rst_trips_b", int'(trips_b), 0);
        rst_n = 1'b1;
    endtask

    task automatic trip_a();
        for (int i = 0; i < TRIP_COUNT; i++) step(1, 0, 3100);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        int tr;
        rst_n = 1'b0;
        ena = 0; enb = 0; pa = 0; pb = 0;
        smp_if.sample_valid = 0; smp_if.sample_ch = 0; smp_if.sample_data = '0;
        model_reset();

        tbl[0]  = '{1'b1, 1'b0, 12'd3100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 12'd3100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 12'd3100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[3]  = '{1'b1, 1'b0, 12'd2999, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 12'd3100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[5]  = '{1'b1, 1'b1, 12'd3100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[6]  = '{1'b0, 1'b0, 12'd0,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[7]  = '{1'b1, 1'b0, 12'd3000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[8]  = '{1'b1, 1'b0, 12'd4095, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[9]  = '{1'b1, 1'b0, 12'd3100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
        tbl[10] = '{1'b0, 1'b0, 12'd0,    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};

        #2;
        do_reset();

        for (int i = 0; i < 11; i++) begin
            ena = tbl[i].en;
            pa  = tbl[i].p;
            step(tbl[i].v, tbl[i].ch, int'(tbl[i].d));
            check($sformatf("tbl%0d_oca", i), int'(oca), int'(tbl[i].oca));
            check($sformatf("tbl%0d_ocb", i), int'(ocb), int'(tbl[i].ocb));
            check($sformatf("tbl%0d_pwma", i), int'(pwma), int'(tbl[i].pwma));
            check($sformatf("tbl%0d_trips_a", i), int'(trips_a), int'(tbl[i].tra));
        end

        // Safe samples during hold are ignored; over sample on the expiry edge too
        for (int i = 0; i < HOLD - 2; i++) step(1, 0, 2000);
        check("hold_oca", int'(oca), 1);
        step(1, 0, 3100);
        check("expiry_over_ignored", int'(trips_a), 1);
        for (int i = 0; i < CLEAR_COUNT - 1; i++) begin
            step(1, 0, 2000);
            check("clear_pending_oca", int'(oca), 1);
        end
        step(1, 0, 2000);
        check("clear_oca", int'(oca), 0);

        // Mid-band sample restarts the clear run
        trip_a();
        idle(HOLD);
        for (int i = 0; i < 5; i++) step(1, 0, 2000);
        step(1, 0, 2700);
        for (int i = 0; i < CLEAR_COUNT - 1; i++) begin
            step(1, 0, 2000);
            check("restart_pending_oca", int'(oca), 1);
        end
        step(1, 0, 2000);
        check("restart_clear_oca", int'(oca), 0);
        check("restart_trips_a", int'(trips_a), 2);

        // Re-trip from CLEARING restarts the full hold
        trip_a();
        idle(HOLD);
        step(1, 0, 3100);
        check("retrip_trips_a", int'(trips_a), 4);
        check("retrip_oca", int'(oca), 1);
        idle(HOLD - 2);
        step(1, 0, 3100);
        check("retrip_hold_ignores", int'(trips_a), 4);
        idle(1);
        for (int i = 0; i < CLEAR_COUNT - 1; i++) step(1, 0, 2000);
        check("retrip_pending_oca", int'(oca), 1);
        step(1, 0, 2000);
        check("retrip_clear_oca", int'(oca), 0);

        // PWM follows input one cycle later and drops with enable
        ena = 1;
        for (int i = 0; i < 6; i++) begin
            pa = (i % 2 == 0);
            step(0, 0, 0);
            check("pwm_follow", int'(pwma), int'(pa));
        end
        pa = 1; ena = 0;
        step(0, 0, 0);
        check("pwm_ena_drop", int'(pwma), 0);
        ena = 1;
        step(0, 0, 0);
        check("pwm_ena_back", int'(pwma), 1);

        trip_a();
        check("pre_reset_oca", int'(oca), 1);
        do_reset();

        // Saturation of the trip counter
        trip_a();
        for (int i = 0; i < 300; i++) begin
            idle(HOLD);
            step(1, 0, 3100);
        end
        check("trips_a_saturated", int'(trips_a), 255);
        do_reset();

        // Random traffic with occasional asynchronous reset
        for (int i = 0; i < 4000; i++) begin
            int kind;
            int d;
            kind = int'($urandom_range(0, 7));
            case (kind)
                0, 1:    d = int'($urandom_range(TRIP_HI, 4095));
                2, 3, 4: d = int'($urandom_range(0, TRIP_LO));
                5:       d = int'($urandom_range(TRIP_LO + 1, TRIP_HI - 1));
                6:       d = (($urandom_range(0, 1) == 1) ? TRIP_HI : TRIP_HI - 1);
                default: d = (($urandom_range(0, 1) == 1) ? TRIP_LO : TRIP_LO + 1);
            endcase
            pa = 1'($urandom_range(0, 1));
            pb = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) ena = ~ena;
            if ($urandom_range(0, 19) == 0) enb = ~enb;
            step($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), d);
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        tr = m_trips[0] + m_trips[1];
        check("random_total_trips", int'(trips_a) + int'(trips_b), tr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/overcurrent_sense.md
# overcurrent_sense

Per-channel overcurrent detector that sits between the current-sense ADC sample stream and the overcurrent enable controller. It sits upstream of the controller that drives the motor-driver enables: it produces the OCA/OCB fault flags that controller consumes, and it accepts that controller's ENA/ENB back. The detector qualifies trips over several consecutive samples, holds a fault for a minimum time, and clears it only after hysteresis-qualified recovery. It also gates the two PWM drive signals by enable and fault, and keeps a saturating trip count per channel.

## Interface
- DATA_W, 12, ADC sample width (unsigned)
- TRIP_HI, 3000, trip threshold; sample >= TRIP_HI is "over"
- TRIP_LO, 2500, clear threshold; sample <= TRIP_LO is "safe"; must be < TRIP_HI
- TRIP_COUNT, 4, consecutive over samples needed to trip (>= 1, <= 255)
- CLEAR_COUNT, 8, consecutive safe samples needed to clear (>= 1, <= 255)
- HOLD_CYCLES, 1000000, minimum fault hold in clk cycles (>= 1, < 2^26)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- sample_valid  in  1  one-cycle strobe; sample_ch/sample_data valid this cycle
- sample_ch  in  1  0 = channel A, 1 = channel B
- sample_data  in  DATA_W  unsigned current-sense value
- ENA, ENB  in  1  enables from the overcurrent controller
- pwm_a_in, pwm_b_in  in  1  raw PWM from the speed controller
- OCA, OCB  out  1  registered fault flag per channel
- PWMA, PWMB  out  1  registered gated PWM
- trips_a, trips_b  out  8  saturating count of FAULT entries per channel

## Operation
- Two identical, independent channel FSMs. A sample updates only the FSM selected by sample_ch. Cycles without sample_valid leave the sample counters unchanged.
- NORMAL (OC=0):
  - over sample -> trip_cnt=1.
  - If TRIP_COUNT==1, go to FAULT; otherwise go to PENDING.
  - Other samples -> stay.
- PENDING (OC=0):
  - over sample -> trip_cnt+1; when the new value equals TRIP_COUNT, go to FAULT.
  - Non-over sample -> trip_cnt=0, go to NORMAL.
- FAULT (OC=1):
  - hold_cnt loads 0 on entry and increments every clk.
  - After HOLD_CYCLES cycles in FAULT, go to CLEARING with clr_cnt=0.
  - Samples are ignored.
- CLEARING (OC=1):
  - safe sample -> clr_cnt+1; when the new value equals CLEAR_COUNT, go to NORMAL and clear trip_cnt.
  - Sample between the thresholds (TRIP_LO < s < TRIP_HI) -> clr_cnt=0, stay.
  - over sample -> back to FAULT with hold restarted (re-trip, single sample, no TRIP_COUNT qualification).
- trips_x increments on every entry into FAULT, including re-trips, and saturates at 255.
- PWMx <= pwm_x_in & ENx & ~OCx (OCx here is the current registered value).

## Timing
- Reset (asynchronous assert, synchronous release behaviour irrelevant): both FSMs go to NORMAL. OCA=OCB=0, PWMA=PWMB=0, trips_a=trips_b=0, all counters 0. Reset mid-fault clears the fault immediately.
- Trip latency: OCx rises on the rising edge that accepts the qualifying sample, so it is visible the cycle after that sample_valid.
- Hold: FAULT entered at edge N; CLEARING entered at edge N+HOLD_CYCLES. A sample accepted at edge N+HOLD_CYCLES or later counts toward clearing.
- Clear latency: OCx falls on the edge that accepts the CLEAR_COUNT-th consecutive safe sample.
- PWM gating: one register stage, so PWMx lags pwm_x_in/ENx by 1 cycle. A PWMx pulse can continue for one cycle after OCx rises; PWMx is forced low from the following edge.
- Width rules:
  - Comparisons are unsigned over DATA_W.
  - trip_cnt and clr_cnt are 8 bits; hold_cnt is 26 bits.
  - No counter wraps: the trip and clear counters are bounded by their state transitions, and trips_x saturates.
- Simultaneous events: a sample for channel B never affects channel A. The hold expiry edge coinciding with an over sample is handled as entering CLEARING, with that sample ignored.

## Test plan
1. Reset, then 4 channel-A samples of 3100 on consecutive strobes -> OCA=1 the cycle after the 4th; trips_a=1; OCB=0, PWMA forced 0.
2. Channel-A samples 3100, 3100, 3100, 2000, 3100 -> OCA stays 0; PENDING resets on 2000.
3. HOLD_CYCLES=16: trip A, then feed 8 samples of 2000 during the hold and 8 samples of 2000 after it -> OCA stays 1 until the 8th post-hold safe sample, then falls.
4. In CLEARING, feed 5x2000, 1x2700, 8x2000 -> clear count restarts at 2700; OCA falls after the final 8th sample.
5. In CLEARING, feed 3100 -> immediate re-entry to FAULT, hold restarts (16 cycles), trips_a increments to 2.
6. ENA=1 with pwm_a_in toggling: PWMA follows delayed by 1 cycle. Drop ENA -> PWMA=0 next cycle. Assert rst_n=0 mid-fault -> OCA=0, PWMA=0, trips_a=0 immediately. Trip A 300 times -> trips_a=255.
